// File: rtl/key_debounce_scheduler_pkg.sv
// Shared definitions for the key debounce blocks:
// FSM state encodings and the default debounce window.
package key_debounce_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam int DEF_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/key_debounce_scheduler_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or
// above ptr, wrapping around. Purely combinational.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            any_req
);

    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest one wins
    always_comb begin
        gnt_id = '0;
        w_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = ID_W'((int'(ptr) + i) % N);
            if (req[w_idx]) begin
                gnt_id = w_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/key_debounce_scheduler.sv
// Debounces N active-low keys with one shared timer,
// handed out round-robin; emits one pulse per accepted press.
module key_debounce_scheduler
    import key_debounce_scheduler_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int ID_W            = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_pulse,
    output logic              event_valid,
    output logic [ID_W-1:0]   event_id,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] r_s0;
    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;
    logic [N_KEYS-1:0] r_pend;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_gnt;
    logic [CNT_W-1:0]  r_timer;
    logic [1:0]        r_state;
    logic [N_KEYS-1:0] r_pulse;
    logic              r_evalid;
    logic [ID_W-1:0]   r_eid;

    logic [N_KEYS-1:0] w_fall;
    logic [N_KEYS-1:0] w_clr;
    logic [N_KEYS-1:0] w_pend_nxt;
    logic [ID_W-1:0]   w_gnt;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              w_any;
    logic              w_bounce;

    assign w_fall    = r_s2 & ~r_s1;
    assign w_bounce  = (r_state == ST_COUNT) && w_fall[r_gnt];
    assign w_ptr_nxt = (r_gnt == ID_W'(N_KEYS - 1))
                     ? '0 : r_gnt + ID_W'(1);

    rr_arbiter #(
        .N    (N_KEYS),
        .ID_W (ID_W)
    ) u_arb (
        .req     (r_pend),
        .ptr     (r_ptr),
        .gnt_id  (w_gnt),
        .any_req (w_any)
    );

    // Two-stage synchroniser plus a delayed copy for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= '1;
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s0 <= key_in;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // Granted key drops its request; a bounce on the owner is not
    // a new request, it only restarts the window
    always_comb begin
        w_clr = '0;
        if (r_state == ST_IDLE && w_any) begin
            w_clr[w_gnt] = 1'b1;
        end
        if (r_state == ST_COUNT) begin
            w_clr[r_gnt] = 1'b1;
        end
        w_pend_nxt = (r_pend | w_fall) & ~w_clr;
    end

    // Request latch: falls set, grants clear, repeats are absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Shared timer ownership: grant, count window, final level check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_timer <= '0;
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_bounce) begin
                        r_timer <= '0;
                    end else if (r_timer == TMR_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    r_ptr   <= w_ptr_nxt;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered one-cycle event when the owner is still pressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse  <= '0;
            r_evalid <= 1'b0;
            r_eid    <= '0;
        end else begin
            r_pulse  <= '0;
            r_evalid <= 1'b0;
            r_eid    <= '0;
            if (r_state == ST_CHECK && !r_s1[r_gnt]) begin
                r_pulse  <= N_KEYS'(1) << r_gnt;
                r_evalid <= 1'b1;
                r_eid    <= r_gnt;
            end
        end
    end

    assign key_pulse   = r_pulse;
    assign event_valid = r_evalid;
    assign event_id    = r_eid;
    assign busy        = (r_state == ST_COUNT) || (r_state == ST_CHECK);

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// Scoreboard bench for key_debounce_scheduler:
// expected pulses (key, cycle) queued at stimulus time.
module tb_key_debounce_scheduler;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  key_in;
    logic [N-1:0]  key_pulse;
    logic          event_valid;
    logic [IW-1:0] event_id;
    logic          busy;

    typedef struct {
        int id;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   total;
    int   bad;

    key_debounce_scheduler #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .ID_W            (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_pulse   (key_pulse),
        .event_valid (event_valid),
        .event_id    (event_id),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int id, input int due);
        exp_t e;
        e.id  = id;
        e.due = due;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: every pulse must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (key_pulse != '0 && !event_valid) begin
                check("pulse_without_valid", int'(key_pulse), 0);
            end
            if (event_valid) begin
                if (q.size() == 0) begin
                    check("spurious_pulse", int'(event_id) + 1, 0);
                end else begin
                    e = q.pop_front();
                    check("event_id", int'(event_id), e.id);
                    check("key_pulse", int'(key_pulse), 1 << e.id);
                    check("pulse_cycle", cyc, e.due);
                    check("busy_at_pulse", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        int c;
        cyc    = 0;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        key_in = '1;
        idle(3);
        check("rst_pulse", int'(key_pulse), 0);
        check("rst_valid", int'(event_valid), 0);
        check("rst_id", int'(event_id), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        idle(2);

        // clean press on key 1, held long: exactly one pulse
        c = cyc;
        key_in[1] = 1'b0;
        expect_ev(1, c + 3 + D + 2);
        idle(4);
        check("busy_clean", int'(busy), 1);
        idle(60);
        key_in = '1;
        idle(10);

        // ptr=2, keys 0 and 3 together; key 0 re-pressed while waiting
        c = cyc;
        key_in = 4'b0110;
        expect_ev(3, c + 21);
        expect_ev(0, c + 39);
        idle(5);
        key_in[0] = 1'b1;
        idle(3);
        key_in[0] = 1'b0;
        idle(55);
        key_in = '1;
        idle(10);

        // bouncy press on key 2: window restarts on each fall
        key_in[2] = 1'b0;
        idle(2);
        key_in[2] = 1'b1;
        idle(2);
        key_in[2] = 1'b0;
        idle(2);
        key_in[2] = 1'b1;
        idle(2);
        c = cyc;
        key_in[2] = 1'b0;
        expect_ev(2, c + 20);
        idle(45);
        key_in = '1;
        idle(10);

        // glitch on key 0: rejected at check, timer released
        c = cyc;
        key_in[0] = 1'b0;
        idle(5);
        check("busy_glitch", int'(busy), 1);
        key_in[0] = 1'b1;
        idle(25);
        check("busy_after_reject", int'(busy), 0);

        // ptr now 1: keys 0 and 1 together -> 1 first
        c = cyc;
        key_in = 4'b1100;
        expect_ev(1, c + 21);
        expect_ev(0, c + 39);
        idle(50);
        key_in = '1;
        idle(10);

        // reset mid-window aborts key 2
        key_in[2] = 1'b0;
        idle(10);
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_valid", int'(event_valid), 0);
        check("rst_mid_pulse", int'(key_pulse), 0);
        key_in = '1;
        idle(3);
        rst = 1'b0;
        idle(40);
        c = cyc;
        key_in[2] = 1'b0;
        expect_ev(2, c + 21);
        idle(30);
        key_in = '1;
        idle(5);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // ptr=0, keys 0,1,3 together: 0,1,3 spaced D+2 apart
        c = cyc;
        key_in = 4'b0100;
        expect_ev(0, c + 21);
        expect_ev(1, c + 39);
        expect_ev(3, c + 57);
        idle(22);
        check("busy_regrant1", int'(busy), 1);
        idle(18);
        check("busy_regrant2", int'(busy), 1);
        idle(40);
        key_in = '1;
        idle(10);

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
